// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory port arbiter: owner tags, sizing defaults, pipeline records.
// Latency: n/a (types only).
// Backpressure: n/a.
package kgp_imem_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int MEM_SIZE_DEF = 32;

    // Bit positions of each requester in the arbiter request/grant vectors
    localparam int FETCH_IDX = 0;
    localparam int LOAD_IDX  = 1;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_e;

    typedef struct packed {
        logic                 valid;
        owner_e               owner;
        logic                 we;
        logic                 oor;
        logic [WIDTH_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   we;
        logic   oor;
    } rsp_tag_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Requester-side bundle: fetch (read-only) and loader (read/write) request/grant/response signals.
// Latency: grant combinational, response 2 cycles after grant.
// Backpressure: requests held until grant; responses cannot be stalled.
interface imem_port_arbiter_if import kgp_imem_pkg::*; #(parameter int WIDTH = WIDTH_DEF);

    logic             fetch_req;
    logic [WIDTH-1:0] fetch_addr;
    logic             fetch_gnt;
    logic [WIDTH-1:0] fetch_rdata;
    logic             fetch_valid;
    logic             fetch_err;

    logic             load_req;
    logic             load_we;
    logic [WIDTH-1:0] load_addr;
    logic [WIDTH-1:0] load_wdata;
    logic             load_gnt;
    logic [WIDTH-1:0] load_rdata;
    logic             load_valid;
    logic             load_err;

    modport master (
        output fetch_req, fetch_addr,
        output load_req, load_we, load_addr, load_wdata,
        input  fetch_gnt, fetch_rdata, fetch_valid, fetch_err,
        input  load_gnt, load_rdata, load_valid, load_err
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_req, load_we, load_addr, load_wdata,
        output fetch_gnt, fetch_rdata, fetch_valid, fetch_err,
        output load_gnt, load_rdata, load_valid, load_err
    );

endinterface

// File: rtl/imem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with a load-priority override.
// Latency: combinational grant; pointer updates on the edge after a grant.
// Backpressure: a losing requester simply stays pending.
module rr_arbiter2 import kgp_imem_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       prio_load,
    output logic [1:0] gnt
);

    // Set when fetch was granted last, so load wins the next tie
    logic prefer_load;

    always_comb begin
        gnt = '0;
        if (req[LOAD_IDX] && (prio_load || !req[FETCH_IDX] || prefer_load)) begin
            gnt[LOAD_IDX] = 1'b1;
        end else if (req[FETCH_IDX]) begin
            gnt[FETCH_IDX] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_load <= 1'b0;
        end else if (|gnt) begin
            prefer_load <= gnt[FETCH_IDX];
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction memory between fetch and loader; traps out-of-range addresses.
// Latency: grant combinational, memory command 1 cycle later, tagged response 2 cycles after grant.
// Backpressure: one grant per cycle, losers held; responses are fire-and-forget pulses.
module imem_port_arbiter import kgp_imem_pkg::*; #(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boot_mode,
    imem_port_arbiter_if.slave  rq,
    output logic                mem_we,
    output logic [WIDTH-1:0]    mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                busy
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       fetch_oor;
    logic       load_oor;
    cmd_t       win_cmd;
    cmd_t       s1;
    rsp_tag_t   s2;
    logic       rsp_data_ok;

    assign req[FETCH_IDX] = rq.fetch_req;
    assign req[LOAD_IDX]  = rq.load_req;

    assign fetch_oor = rq.fetch_addr >= WIDTH'(MEM_SIZE);
    assign load_oor  = rq.load_addr  >= WIDTH'(MEM_SIZE);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .prio_load (boot_mode),
        .gnt       (gnt)
    );

    assign rq.fetch_gnt = gnt[FETCH_IDX];
    assign rq.load_gnt  = gnt[LOAD_IDX];

    // Out-of-range commands carry zero address/data so the memory port never sees them
    always_comb begin
        win_cmd       = '0;
        win_cmd.owner = OWN_FETCH;
        if (gnt[LOAD_IDX]) begin
            win_cmd.valid = 1'b1;
            win_cmd.owner = OWN_LOAD;
            win_cmd.we    = rq.load_we;
            win_cmd.oor   = load_oor;
            win_cmd.addr  = load_oor ? '0 : rq.load_addr;
            win_cmd.wdata = load_oor ? '0 : rq.load_wdata;
        end else if (gnt[FETCH_IDX]) begin
            win_cmd.valid = 1'b1;
            win_cmd.owner = OWN_FETCH;
            win_cmd.oor   = fetch_oor;
            win_cmd.addr  = fetch_oor ? '0 : rq.fetch_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1 <= win_cmd;
        end
    end

    assign mem_we    = s1.valid && s1.we && !s1.oor;
    assign mem_addr  = s1.addr;
    assign mem_wdata = s1.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2 <= '0;
        end else begin
            s2.valid <= s1.valid;
            s2.owner <= s1.owner;
            s2.we    <= s1.we;
            s2.oor   <= s1.oor;
        end
    end

    // Memory read data arrives in the same cycle as the response pulse
    assign rsp_data_ok    = s2.valid && !s2.we && !s2.oor;

    assign rq.fetch_valid = s2.valid && (s2.owner == OWN_FETCH);
    assign rq.fetch_err   = rq.fetch_valid && s2.oor;
    assign rq.fetch_rdata = (rq.fetch_valid && rsp_data_ok) ? mem_rdata : '0;

    assign rq.load_valid  = s2.valid && (s2.owner == OWN_LOAD);
    assign rq.load_err    = rq.load_valid && s2.oor;
    assign rq.load_rdata  = (rq.load_valid && rsp_data_ok) ? mem_rdata : '0;

    assign busy = s1.valid || s2.valid;

endmodule
